// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHK,
        CLR,
        LOAD,
        POST,
        RUN,
        ERROR
    } state_t;

    localparam int DEFAULT_DEPTH = 32;
    localparam int BYTE_LANES    = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream image channel into the loader.
// Valid/ready: a byte moves on a rising clock edge when byte_valid && byte_ready;
// the source holds byte_in stable while byte_valid is high and not yet accepted.
interface program_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/word_buffer.sv
// DEPTH x 32 program word store: synchronous write, asynchronous read.
module word_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (waddr < LIMIT)) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // The read pointer parks at N after the last word, which can equal DEPTH.
    assign rdata = (raddr < LIMIT) ? mem[raddr[IW-1:0]] : 32'h0;

endmodule

// File: rtl/program_loader.sv
// Assembles a byte-stream program image into words and streams it into the CPU.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   Reset,
    program_loader_if.slave        bus,
    input  logic                   reload,
    output logic                   cpu_reset,
    output logic                   cpu_load,
    output logic [31:0]            cpu_instr,
    output logic                   done,
    output logic                   err,
    output state_t                 dbg_state
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [8:0]    DEPTH_LIM = 9'(DEPTH);
    localparam logic [1:0]    LAST_LANE = 2'(BYTE_LANES - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [1:0]    lane;
    logic [23:0]   asm_q;
    logic          fire;
    logic          wr_en;
    logic          count_ok;
    logic [31:0]   wr_data;
    logic [31:0]   rd_data;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    // Gated by Reset so the channel is closed while the loader is held in reset.
    assign bus.byte_ready = Reset && ((state == IDLE) || (state == RECV) || (state == CHK));
    assign fire      = bus.byte_valid && bus.byte_ready;
    assign wr_en     = fire && (state == RECV) && (lane == LAST_LANE);
    assign wr_data   = {asm_q, bus.byte_in};
    assign count_ok  = (bus.byte_in != 8'h00) && ({1'b0, bus.byte_in} <= DEPTH_LIM);
    assign dbg_state = state;

    word_buffer #(.DEPTH(DEPTH), .AW(CW)) u_word_buffer (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lane      <= '0;
            asm_q     <= '0;
            cpu_reset <= 1'b1;
            cpu_load  <= 1'b0;
            cpu_instr <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= bus.byte_in;
`endif
                        if (count_ok) begin
                            count <= bus.byte_in[CW-1:0];
                            state <= RECV;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (fire) begin
                        asm_q <= wr_data[23:0];
                        lane  <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum  <= csum ^ bus.byte_in;
`endif
                        if (lane == LAST_LANE) begin
                            wr_ptr <= wr_ptr + ONE;
                            if (wr_ptr + ONE == count) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= CHK;
`else
                                state <= CLR;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (fire) begin
                        if (bus.byte_in == csum) begin
                            state <= CLR;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                CLR: begin
                    // First word is presented on the same edge that enters LOAD.
                    state     <= LOAD;
                    cpu_reset <= 1'b0;
                    cpu_load  <= 1'b1;
                    cpu_instr <= rd_data;
                    rd_ptr    <= rd_ptr + ONE;
                end
                LOAD: begin
                    if (rd_ptr == count) begin
                        state     <= POST;
                        cpu_load  <= 1'b0;
                        cpu_instr <= '0;
                        cpu_reset <= 1'b1;
                    end else begin
                        cpu_instr <= rd_data;
                        rd_ptr    <= rd_ptr + ONE;
                    end
                end
                POST: begin
                    state     <= RUN;
                    cpu_reset <= 1'b0;
                    done      <= 1'b1;
                end
                RUN: begin
                    if (reload) begin
                        state     <= IDLE;
                        done      <= 1'b0;
                        cpu_reset <= 1'b1;
                        lane      <= '0;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                    end
                end
                ERROR: begin
                    if (reload) begin
                        state  <= IDLE;
                        err    <= 1'b0;
                        lane   <= '0;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a word-list reference of each image.
module tb_program_loader;
    import loader_pkg::*;

    localparam int DEPTH = DEFAULT_DEPTH;

    logic        clk = 1'b0;
    logic        Reset;
    logic        reload = 1'b0;
    logic        cpu_reset;
    logic        cpu_load;
    logic [31:0] cpu_instr;
    logic        done;
    logic        err;
    state_t      dbg_state;

    program_loader_if bus();

    program_loader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .bus       (bus),
        .reload    (reload),
        .cpu_reset (cpu_reset),
        .cpu_load  (cpu_load),
        .cpu_instr (cpu_instr),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  img_q[$];
    logic [31:0] exp_q[$];

    // Serialises exp_q into an image: count byte, big-endian words, optional checksum.
    task automatic build_image(input bit corrupt_csum);
        logic [7:0] x;
        img_q.delete();
        img_q.push_back(8'(exp_q.size()));
        foreach (exp_q[i]) begin
            img_q.push_back(exp_q[i][31:24]);
            img_q.push_back(exp_q[i][23:16]);
            img_q.push_back(exp_q[i][15:8]);
            img_q.push_back(exp_q[i][7:0]);
        end
`ifdef LOADER_CHECKSUM_EN
        x = 8'h00;
        foreach (img_q[i]) x = x ^ img_q[i];
        img_q.push_back(corrupt_csum ? (x ^ 8'h01) : x);
`else
        x = {7'd0, corrupt_csum};
`endif
    endtask

    task automatic random_words(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back($urandom);
    endtask

    task automatic send_image(input bit gaps, input bit rand_reload, output int stalls, output int cycles);
        bit accepted;
        int tries;
        stalls = 0;
        cycles = 0;
        foreach (img_q[i]) begin
            accepted = 1'b0;
            tries = 0;
            while (!accepted && tries < 64) begin
                @(negedge clk);
                bus.byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.byte_in    = img_q[i];
                reload         = rand_reload ? ($urandom_range(0, 3) == 0) : 1'b0;
                accepted       = bus.byte_valid && bus.byte_ready;
                if (bus.byte_valid && !bus.byte_ready) stalls++;
                @(posedge clk);
                tries++;
                cycles++;
            end
            n_vec++;
            if (!accepted) begin
                n_err++;
                $display("FAIL byte_accept idx=%0d: got no transfer, required transfer within 64 cycles", i);
            end
        end
    endtask

    // Expected sequence after the last accepted byte: CLR, N LOAD cycles, POST, RUN.
    task automatic check_load(input int n, input string tag);
        logic [31:0] w;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        reload = ($urandom_range(0, 3) == 0);
        n_vec++;
        if ({cpu_reset, cpu_load, done, bus.byte_ready} !== 4'b1000) begin
            n_err++;
            $display("FAIL %s clr: got rst/load/done/rdy=%b%b%b%b, required 1000", tag, cpu_reset, cpu_load, done, bus.byte_ready);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reload = ($urandom_range(0, 3) == 0);
            w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            n_vec++;
            if (cpu_load !== 1'b1 || cpu_reset !== 1'b0 || cpu_instr !== w) begin
                n_err++;
                $display("FAIL %s load[%0d]: got load=%b rst=%b instr=%h, required load=1 rst=0 instr=%h", tag, k, cpu_load, cpu_reset, cpu_instr, w);
            end
        end
        @(negedge clk);
        reload = 1'b0;
        n_vec++;
        if (cpu_reset !== 1'b1 || cpu_load !== 1'b0 || cpu_instr !== 32'h0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s post: got rst=%b load=%b instr=%h done=%b, required 1 0 0 0", tag, cpu_reset, cpu_load, cpu_instr, done);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || err !== 1'b0 || dbg_state !== RUN) begin
            n_err++;
            $display("FAIL %s run: got done=%b rst=%b err=%b state=%s, required done=1 rst=0 err=0 RUN", tag, done, cpu_reset, err, dbg_state.name());
        end
    endtask

    task automatic do_reload(input string tag);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        n_vec++;
        if (done !== 1'b0 || err !== 1'b0 || bus.byte_ready !== 1'b1 || cpu_reset !== 1'b1 || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL %s reload: got done=%b err=%b rdy=%b rst=%b state=%s, required 0 0 1 1 IDLE", tag, done, err, bus.byte_ready, cpu_reset, dbg_state.name());
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        #2 Reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (bus.byte_ready !== 1'b0 || cpu_reset !== 1'b1 || cpu_load !== 1'b0 || cpu_instr !== 32'h0
            || done !== 1'b0 || err !== 1'b0 || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_values: got rdy=%b rst=%b load=%b instr=%h done=%b err=%b, required 0 1 0 0 0 0",
                     bus.byte_ready, cpu_reset, cpu_load, cpu_instr, done, err);
        end
        Reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus.byte_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b, required 1", bus.byte_ready);
        end
    endtask

    task automatic test_basic();
        int stalls, cycles;
        exp_q.delete();
        exp_q.push_back(32'h2001_0005);
        build_image(1'b0);
        send_image(1'b0, 1'b0, stalls, cycles);
        check_load(1, "basic");
    endtask

    task automatic test_reload();
        int stalls, cycles;
        do_reload("reload");
        random_words(2);
        build_image(1'b0);
        send_image(1'b1, 1'b1, stalls, cycles);
        check_load(2, "reload");
    endtask

    task automatic test_random_loads();
        int stalls, cycles;
        for (int r = 0; r < 4; r++) begin
            do_reload("random");
            random_words($urandom_range(1, 8));
            build_image(1'b0);
            send_image(1'b1, 1'b1, stalls, cycles);
            check_load(8'(img_q[0]), "random");
        end
    endtask

    task automatic test_back_to_back();
        int stalls, cycles;
        do_reload("b2b");
        random_words(DEPTH);
        build_image(1'b0);
        send_image(1'b0, 1'b0, stalls, cycles);
        n_vec++;
        if (stalls !== 0 || cycles !== img_q.size()) begin
            n_err++;
            $display("FAIL b2b_stream: got stalls=%0d cycles=%0d, required stalls=0 cycles=%0d", stalls, cycles, img_q.size());
        end
        check_load(DEPTH, "b2b");
        do_reload("b2b_exit");
    endtask

    task automatic test_bad_count(input logic [7:0] c);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_in = c;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        n_vec++;
        if (err !== 1'b1 || cpu_reset !== 1'b1 || bus.byte_ready !== 1'b0 || cpu_load !== 1'b0 || dbg_state !== ERROR) begin
            n_err++;
            $display("FAIL bad_count %h: got err=%b rst=%b rdy=%b load=%b, required 1 1 0 0", c, err, cpu_reset, bus.byte_ready, cpu_load);
        end
        do_reload("bad_count");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum_mismatch();
        int stalls, cycles;
        bit saw_load;
        exp_q.delete();
        exp_q.push_back(32'h2001_0005);
        build_image(1'b1);
        send_image(1'b1, 1'b0, stalls, cycles);
        saw_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            if (cpu_load !== 1'b0) saw_load = 1'b1;
        end
        n_vec++;
        if (saw_load || err !== 1'b1 || cpu_reset !== 1'b1 || dbg_state !== ERROR) begin
            n_err++;
            $display("FAIL csum_mismatch: got load_seen=%b err=%b rst=%b, required 0 1 1", saw_load, err, cpu_reset);
        end
        do_reload("csum");
    endtask
`endif

    task automatic test_reset_mid_load();
        int stalls, cycles;
        random_words(4);
        build_image(1'b0);
        send_image(1'b1, 1'b0, stalls, cycles);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (cpu_load !== 1'b1 || cpu_instr !== exp_q[1]) begin
            n_err++;
            $display("FAIL mid_load_pre: got load=%b instr=%h, required load=1 instr=%h", cpu_load, cpu_instr, exp_q[1]);
        end
        #2 Reset = 1'b0;
        #1;
        n_vec++;
        if (bus.byte_ready !== 1'b0 || cpu_reset !== 1'b1 || cpu_load !== 1'b0 || cpu_instr !== 32'h0
            || done !== 1'b0 || err !== 1'b0 || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL mid_load_abort: got rdy=%b rst=%b load=%b instr=%h done=%b err=%b, required 0 1 0 0 0 0",
                     bus.byte_ready, cpu_reset, cpu_load, cpu_instr, done, err);
        end
        @(negedge clk);
        Reset = 1'b1;
        random_words($urandom_range(1, 6));
        build_image(1'b0);
        send_image(1'b1, 1'b0, stalls, cycles);
        check_load(8'(img_q[0]), "after_reset");
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_in = 8'h00;
        test_reset();
        test_basic();
        test_reload();
        test_random_loads();
        test_back_to_back();
        test_bad_count(8'h00);
        test_bad_count(8'(DEPTH + 1));
        test_bad_count(8'($urandom_range(DEPTH + 1, 255)));
`ifdef LOADER_CHECKSUM_EN
        test_checksum_mismatch();
`endif
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
